// File: rtl/fp_round_pkg.sv
// Shared types and constants for the binary64 normalize-and-round pipeline.
package fp_round_pkg;

  localparam int PIPE_STAGES = 3;
  localparam int BIAS        = 1023;

  localparam logic signed [12:0] EMAX   = 13'sd2046;
  localparam logic [63:0]        QNAN   = 64'h7FF8_0000_0000_0000;
  localparam logic [62:0]        MAXFIN = 63'h7FEF_FFFF_FFFF_FFFF;

  typedef enum logic [1:0] {
    RM_RNE = 2'b00,
    RM_RZ  = 2'b01,
    RM_RU  = 2'b10,
    RM_RD  = 2'b11
  } rm_e;

  typedef enum logic [1:0] {
    SP_NONE = 2'b00,
    SP_NAN  = 2'b01,
    SP_INF  = 2'b10,
    SP_ZERO = 2'b11
  } special_e;

  // Payload carried between pipeline stages; sig is {int, frac[52], G, R, S}.
  typedef struct packed {
    logic               sign;
    logic signed [12:0] exp;
    logic [55:0]        sig;
    special_e           special;
    rm_e                rm;
    logic               inexact;
  } stage_t;

  function automatic logic roundUp(input rm_e rm, input logic sign, input logic lsb,
                                   input logic g, input logic r, input logic s);
    logic up;
    case (rm)
      RM_RNE:  up = g & (r | s | lsb);
      RM_RZ:   up = 1'b0;
      RM_RU:   up = ~sign & (g | r | s);
      default: up = sign & (g | r | s);
    endcase
    return up;
  endfunction

endpackage

// File: rtl/fp_round_if.sv
// Handshake and data bundle between the adder, the rounding stage and writeback.
interface fp_round_if;

  logic        in_valid;
  logic        in_ready;
  logic [10:0] es;
  logic [56:0] fs;
  logic        ss;
  logic [1:0]  fls;
  logic        nan_in;
  logic [1:0]  rm;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  logic [2:0]  flags;

  modport master (
    output in_valid, es, fs, ss, fls, nan_in, rm, out_ready,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, es, fs, ss, fls, nan_in, rm, out_ready,
    output in_ready, out_valid, result, flags
  );

endinterface

// File: rtl/fp_lzc56.sv
// Combinational leading-zero counter over a 56-bit significand.
module fp_lzc56 (
  input  logic [55:0] in_i,
  output logic [5:0]  cnt_o,
  output logic        zero_o
);

  // Scan upward so the highest set bit is the last one to set the count.
  always_comb begin
    cnt_o = 6'd56;
    for (int i = 0; i < 56; i++) begin
      if (in_i[i]) cnt_o = 6'(55 - i);
    end
  end

  assign zero_o = ~|in_i;

endmodule

// File: rtl/fp_round.sv
// Three-stage normalize/round/pack stage behind the double-precision adder.
module fp_round
  import fp_round_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  fp_round_if.slave  bus
);

  logic               adv;
  logic               v1_q, v2_q, outValid_q;
  stage_t             s1_d, s1_q, s2_d, s2_q;
  logic [5:0]         lz1_d, lz1_q;
  logic               rndUp2_d, rndUp2_q;
  logic [63:0]        result_d, result_q;
  logic [2:0]         flags_d, flags_q;
  logic [5:0]         lzCnt;
  logic               lzZero;
  logic [5:0]         shAmt;
  logic signed [12:0] shLim;
  logic [55:0]        nsig;
  logic [53:0]        sum;
  logic signed [12:0] e3;
  logic [51:0]        frac;
  logic               tiny, inexact3, towardInf;

  assign adv           = ~outValid_q | bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = outValid_q;
  assign bus.result    = result_q;
  assign bus.flags     = flags_q;

  fp_lzc56 u_lzc (
    .in_i   (bus.fs[55:0]),
    .cnt_o  (lzCnt),
    .zero_o (lzZero)
  );

  // Stage 1: fold a carry-out back into range and classify specials.
  always_comb begin
    s1_d      = '0;
    s1_d.sign = bus.ss;
    s1_d.rm   = rm_e'(bus.rm);
    s1_d.exp  = $signed({2'b00, bus.es}) + (bus.fs[56] ? 13'sd1 : 13'sd0);
    s1_d.sig  = bus.fs[56] ? {bus.fs[56:2], bus.fs[1] | bus.fs[0]} : bus.fs[55:0];
    lz1_d     = bus.fs[56] ? 6'd0 : lzCnt;
    if (bus.nan_in)                          s1_d.special = SP_NAN;
    else if (bus.fls[1])                     s1_d.special = SP_INF;
    else if (bus.fls[0] || (!bus.fs[56] && lzZero)) s1_d.special = SP_ZERO;
    else                                     s1_d.special = SP_NONE;
  end

  // Stage 2: normalize without dropping below the minimum exponent, then decide rounding.
  always_comb begin
    s2_d  = s1_q;
    shAmt = 6'd0;
    shLim = s1_q.exp - 13'sd1;
    if (s1_q.exp > 13'sd1) begin
      shAmt = ($signed({7'b0, lz1_q}) < shLim) ? lz1_q : shLim[5:0];
    end
    nsig         = s1_q.sig << shAmt;
    s2_d.sig     = nsig;
    s2_d.exp     = nsig[55] ? (s1_q.exp - $signed({7'b0, shAmt})) : 13'sd0;
    s2_d.inexact = s1_q.inexact | (|nsig[2:0]);
    rndUp2_d     = roundUp(s1_q.rm, s1_q.sign, nsig[3], nsig[2], nsig[1], nsig[0]);
  end

  // Stage 3: apply the increment, fix up the exponent, handle overflow and pack.
  always_comb begin
    result_d  = '0;
    flags_d   = '0;
    sum       = {1'b0, s2_q.sig[55:3]} + {53'b0, rndUp2_q};
    e3        = s2_q.exp;
    frac      = sum[51:0];
    tiny      = (s2_q.exp == 13'sd0);
    inexact3  = s2_q.inexact | (|s2_q.sig[2:0]);
    towardInf = (s2_q.rm == RM_RNE) || (s2_q.rm == RM_RU && !s2_q.sign) ||
                (s2_q.rm == RM_RD && s2_q.sign);
    if (sum[53]) begin
      frac = '0;
      e3   = e3 + 13'sd1;
    end else if (tiny && sum[52]) begin
      e3 = 13'sd1;
    end
    case (s2_q.special)
      SP_NAN:  result_d = QNAN;
      SP_INF:  result_d = {s2_q.sign, 11'h7FF, 52'b0};
      SP_ZERO: result_d = {s2_q.sign, 63'b0};
      default: begin
        if (e3 > EMAX) begin
          result_d = towardInf ? {s2_q.sign, 11'h7FF, 52'b0} : {s2_q.sign, MAXFIN};
          flags_d  = 3'b101;
        end else begin
          result_d = {s2_q.sign, e3[10:0], frac};
          flags_d  = {1'b0, tiny & inexact3, inexact3};
        end
      end
    endcase
  end

  // Pipeline registers: every stage moves together whenever the output can drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      outValid_q <= 1'b0;
      s1_q       <= '0;
      s2_q       <= '0;
      lz1_q      <= '0;
      rndUp2_q   <= 1'b0;
      result_q   <= '0;
      flags_q    <= '0;
    end else if (adv) begin
      v1_q       <= bus.in_valid;
      s1_q       <= s1_d;
      lz1_q      <= lz1_d;
      v2_q       <= v1_q;
      s2_q       <= s2_d;
      rndUp2_q   <= rndUp2_d;
      outValid_q <= v2_q;
      result_q   <= result_d;
      flags_q    <= flags_d;
    end
  end

endmodule

// File: tb/tb_fp_round.sv
// Scoreboard testbench for the fp_round normalize-and-round pipeline.
module tb_fp_round;
  import fp_round_pkg::*;

  typedef struct {
    logic [63:0] res;
    logic [2:0]  fl;
  } exp_t;

  logic clk;
  logic rst;
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  fp_round_if bus();

  fp_round dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", tag, got, want);
    end
  endtask

  // Drive one operand set, wait (bounded) for acceptance, and record the expected result.
  task automatic applyStimulus(input logic [10:0] es, input logic [56:0] fs, input logic ss,
                               input logic [1:0] fls, input logic nan, input logic [1:0] rm,
                               input logic [63:0] expRes, input logic [2:0] expFl);
    int   n;
    exp_t e;
    bus.es       = es;
    bus.fs       = fs;
    bus.ss       = ss;
    bus.fls      = fls;
    bus.nan_in   = nan;
    bus.rm       = rm;
    bus.in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      checkOutput("accept_timeout", 64'(bus.in_ready), 64'd1);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    e.res = expRes;
    e.fl  = expFl;
    sb.push_back(e);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (sb.size() != 0) checkOutput("drain_timeout", 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Compare each accepted output against the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        checkOutput("spurious_out", 64'(bus.out_valid), 64'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("result", bus.result, e.res);
        checkOutput("flags", 64'(bus.flags), 64'(e.fl));
      end
    end
  end

  initial begin
    logic [51:0] frac;
    logic [10:0] es;
    logic        ss;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.es        = '0;
    bus.fs        = '0;
    bus.ss        = 1'b0;
    bus.fls       = '0;
    bus.nan_in    = 1'b0;
    bus.rm        = RM_RNE;
    bus.out_ready = 1'b1;
    #3;
    checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("rst_result", bus.result, 64'd0);
    checkOutput("rst_flags", 64'(bus.flags), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    checkOutput("rst_in_ready", 64'(bus.in_ready), 64'd1);

    $display("[TB] basic path and latency");
    applyStimulus(11'd1023, 57'd1 << 56, 1'b0, 2'b00, 1'b0, RM_RNE, 64'h4000_0000_0000_0000, 3'b000);
    @(negedge clk);
    checkOutput("lat_edge1", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    checkOutput("lat_edge2", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    checkOutput("lat_edge3", 64'(bus.out_valid), 64'd1);
    waitDrain();

    $display("[TB] rounding, overflow, subnormal and special cases");
    applyStimulus(11'd1023, (57'd1 << 55) | 57'd4,  1'b0, 2'b00, 1'b0, RM_RNE, 64'h3FF0_0000_0000_0000, 3'b001);
    applyStimulus(11'd1023, (57'd1 << 55) | 57'd12, 1'b0, 2'b00, 1'b0, RM_RNE, 64'h3FF0_0000_0000_0002, 3'b001);
    applyStimulus(11'd1023, (57'd1 << 55) | 57'd1,  1'b0, 2'b00, 1'b0, RM_RU,  64'h3FF0_0000_0000_0001, 3'b001);
    applyStimulus(11'd1023, (57'd1 << 55) | 57'd1,  1'b0, 2'b00, 1'b0, RM_RD,  64'h3FF0_0000_0000_0000, 3'b001);
    applyStimulus(11'd2046, {1'b0, {56{1'b1}}},     1'b0, 2'b00, 1'b0, RM_RNE, 64'h7FF0_0000_0000_0000, 3'b101);
    applyStimulus(11'd2047, {1'b0, {56{1'b1}}},     1'b0, 2'b00, 1'b0, RM_RZ,  64'h7FEF_FFFF_FFFF_FFFF, 3'b101);
    applyStimulus(11'd2047, 57'd1 << 55,            1'b1, 2'b00, 1'b0, RM_RU,  64'hFFEF_FFFF_FFFF_FFFF, 3'b101);
    applyStimulus(11'd2047, 57'd1 << 55,            1'b1, 2'b00, 1'b0, RM_RD,  64'hFFF0_0000_0000_0000, 3'b101);
    applyStimulus(11'd1,    57'd1 << 54,            1'b0, 2'b00, 1'b0, RM_RNE, 64'h0008_0000_0000_0000, 3'b000);
    applyStimulus(11'd1,    (57'd1 << 54) | 57'd1,  1'b0, 2'b00, 1'b0, RM_RNE, 64'h0008_0000_0000_0000, 3'b011);
    applyStimulus(11'd1,    (57'd1 << 55) - 57'd1,  1'b0, 2'b00, 1'b0, RM_RNE, 64'h0010_0000_0000_0000, 3'b011);
    applyStimulus(11'd1000, 57'd1 << 30,            1'b0, 2'b00, 1'b0, RM_RNE,
                  {1'b0, 11'(BIAS - 48), 52'b0}, 3'b000);
    applyStimulus(11'd1023, 57'd1 << 55,            1'b0, 2'b10, 1'b1, RM_RNE, 64'h7FF8_0000_0000_0000, 3'b000);
    applyStimulus(11'd1023, 57'd1 << 55,            1'b1, 2'b01, 1'b0, RM_RNE, 64'h8000_0000_0000_0000, 3'b000);
    applyStimulus(11'd1023, 57'd1 << 55,            1'b1, 2'b10, 1'b0, RM_RNE, 64'hFFF0_0000_0000_0000, 3'b000);
    applyStimulus(11'd500,  57'd0,                  1'b0, 2'b00, 1'b0, RM_RU,  64'h0000_0000_0000_0000, 3'b000);
    waitDrain();

    $display("[TB] backpressure");
    bus.out_ready = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      applyStimulus(11'd1023, {2'b01, 52'(k), 3'b000}, 1'b0, 2'b00, 1'b0, RM_RNE,
                    {1'b0, 11'h3FF, 52'(k)}, 3'b000);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput("stall_in_ready", 64'(bus.in_ready), 64'd0);
      checkOutput("stall_valid", 64'(bus.out_valid), 64'd1);
      checkOutput("stall_result", bus.result, 64'h3FF0_0000_0000_0001);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    waitDrain();

    $display("[TB] random exact operands");
    for (int k = 0; k < 10; k++) begin
      frac = {$urandom, $urandom};
      ss   = 1'($urandom);
      es   = 11'($urandom_range(2, 2044));
      if (k % 2 == 0)
        applyStimulus(es, {2'b01, frac, 3'b000}, ss, 2'b00, 1'b0, 2'($urandom), {ss, es, frac}, 3'b000);
      else
        applyStimulus(es, {1'b1, frac, 4'b0000}, ss, 2'b00, 1'b0, 2'($urandom), {ss, es + 11'd1, frac}, 3'b000);
    end
    waitDrain();

    $display("[TB] reset with data in flight");
    bus.out_ready = 1'b0;
    applyStimulus(11'd1023, 57'd1 << 55, 1'b0, 2'b00, 1'b0, RM_RNE, 64'h3FF0_0000_0000_0000, 3'b000);
    applyStimulus(11'd1024, 57'd1 << 55, 1'b0, 2'b00, 1'b0, RM_RNE, 64'h4000_0000_0000_0000, 3'b000);
    for (int k = 0; k < 10 && !bus.out_valid; k++) @(negedge clk);
    checkOutput("pre_rst_valid", 64'(bus.out_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("async_rst_result", bus.result, 64'd0);
    checkOutput("async_rst_flags", 64'(bus.flags), 64'd0);
    sb.delete();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checkOutput("post_rst_idle", 64'(bus.out_valid), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
